// File: rtl/truth_table_sequencer.sv
// Exhaustive 4-input truth-table tester: steps {A,B,C,D} through all 16 patterns,
// holds each for HOLD cycles and scores dut_out against a golden table latched at start.
module truth_table_sequencer #(
    parameter int HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        dut_out,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic [7:0]  hold_cnt;
    logic [7:0]  hold_next;
    logic [15:0] latched_expected;
    logic [15:0] latched_next;
    logic [4:0]  err_q;
    logic [4:0]  err_next;
    logic [3:0]  ff_q;
    logic [3:0]  ff_next;
    logic        fv_q;
    logic        fv_next;
    logic        done_q;
    logic        done_next;

    logic last_hold;
    logic mismatch;

    assign last_hold = (hold_cnt == HOLD_LAST);
    assign mismatch  = (dut_out != latched_expected[idx]);

    // Next-state and datapath; start is only honoured outside RUN.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        hold_next    = hold_cnt;
        latched_next = latched_expected;
        err_next     = err_q;
        ff_next      = ff_q;
        fv_next      = fv_q;
        done_next    = done_q;

        case (state)
            IDLE, FINISH: begin
                if (start) begin
                    state_next   = RUN;
                    idx_next     = 4'd0;
                    hold_next    = 8'd0;
                    latched_next = expected;
                    err_next     = 5'd0;
                    ff_next      = 4'd0;
                    fv_next      = 1'b0;
                    done_next    = 1'b0;
                end
            end
            RUN: begin
                if (last_hold) begin
                    hold_next = 8'd0;
                    if (mismatch) begin
                        if (err_q != 5'd16) begin
                            err_next = err_q + 5'd1;
                        end
                        if (!fv_q) begin
                            ff_next = idx;
                            fv_next = 1'b1;
                        end
                    end
                    // The final compare and the move to FINISH share one edge.
                    if (idx == 4'd15) begin
                        state_next = FINISH;
                        idx_next   = 4'd0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end else begin
                    hold_next = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 4'd0;
                hold_next  = 8'd0;
                done_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= 4'd0;
            hold_cnt         <= 8'd0;
            latched_expected <= 16'd0;
            err_q            <= 5'd0;
            ff_q             <= 4'd0;
            fv_q             <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state            <= state_next;
            idx              <= idx_next;
            hold_cnt         <= hold_next;
            latched_expected <= latched_next;
            err_q            <= err_next;
            ff_q             <= ff_next;
            fv_q             <= fv_next;
            done_q           <= done_next;
        end
    end

    // idx is forced to zero outside RUN, so the stimulus bits need no gating.
    assign {A, B, C, D} = idx;
    assign busy         = (state == RUN);
    assign done         = done_q;
    assign pass         = done_q && (err_q == 5'd0);
    assign err_count    = err_q;
    assign first_fail   = ff_q;
    assign fail_valid   = fv_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer (HOLD=4): a table of full runs plus
// hand-written reset, idle and abort sequences.
module tb_truth_table_sequencer;

    localparam int HOLD = 4;
    localparam int RUN_CYCLES = 16 * HOLD;

    localparam logic [1:0] M_ZERO = 2'd0;
    localparam logic [1:0] M_AND  = 2'd1;
    localparam logic [1:0] M_ONE  = 2'd2;
    localparam logic [1:0] M_PAR  = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected = 16'h0000;
    logic        dut_out;
    logic        A, B, C, D;
    logic        busy, done, pass, fail_valid;
    logic [4:0]  err_count;
    logic [3:0]  first_fail;
    logic [1:0]  mode = M_ZERO;

    int n_checks = 0;
    int n_pass = 0;

    // Function under test, selectable per run.
    assign dut_out = (mode == M_ZERO) ? 1'b0 :
                     (mode == M_AND)  ? (A & B) :
                     (mode == M_ONE)  ? 1'b1 : (A ^ B ^ C ^ D);

    truth_table_sequencer #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .dut_out(dut_out),
        .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail), .fail_valid(fail_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    function automatic int all_outs();
        return int'({A, B, C, D, busy, done, pass, err_count, first_fail, fail_valid});
    endfunction

    typedef struct {
        logic [15:0] exp;
        logic [1:0]  mode;
        int          repulse;
        int          exp_err;
        int          exp_ff;
        int          exp_fv;
    } vec_t;

    vec_t vecs[8];

    // Starts a run, optionally re-pulses start and scrambles expected mid-run,
    // and counts cycles from the accepting edge to done.
    task automatic run_one(input logic [15:0] exp_tab, input int repulse,
                           output int done_cyc, output int step_err, output int accept_err);
        @(negedge clk);
        expected = exp_tab;
        start = 1'b1;
        @(posedge clk);
        #1;
        accept_err = 0;
        if (!busy || done || pass || err_count != 0 || fail_valid || first_fail != 0 ||
            {A, B, C, D} != 4'd0)
            accept_err = 1;
        done_cyc = -1;
        step_err = 0;
        for (int n = 1; n <= RUN_CYCLES + 20; n++) begin
            @(negedge clk);
            start = (n == repulse);
            if (n == repulse) expected = 16'h0000;
            @(posedge clk);
            #1;
            if (done) begin
                done_cyc = n;
                break;
            end
            if (!busy || pass || {A, B, C, D} != 4'(n / HOLD)) step_err++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int dc, se, ae, bad;

        vecs[0] = '{16'hF000, M_AND,  -1,  0,  0, 0};
        vecs[1] = '{16'hF000, M_ZERO, -1,  4, 12, 1};
        vecs[2] = '{16'hF000, M_AND,  20,  0,  0, 0};
        vecs[3] = '{16'h8000, M_AND,  -1,  3, 12, 1};
        vecs[4] = '{16'hFFFF, M_ZERO, -1, 16,  0, 1};
        vecs[5] = '{16'h6996, M_PAR,  -1,  0,  0, 0};
        vecs[6] = '{16'h0000, M_ONE,  -1, 16,  0, 1};
        vecs[7] = '{16'h0001, M_ZERO, -1,  1,  0, 1};

        // Asynchronous reset takes effect with no clock edge.
        #2 rst = 1'b1;
        #1 check("reset_outputs", all_outs(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (all_outs() != 0) bad++;
        end
        check("idle_quiet_100", bad, 0);

        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            run_one(vecs[i].exp, vecs[i].repulse, dc, se, ae);
            check($sformatf("v%0d_accept_clear", i), ae, 0);
            check($sformatf("v%0d_done_cycle", i), dc, RUN_CYCLES);
            check($sformatf("v%0d_pattern_steps", i), se, 0);
            check($sformatf("v%0d_err_count", i), int'(err_count), vecs[i].exp_err);
            check($sformatf("v%0d_first_fail", i), int'(first_fail), vecs[i].exp_ff);
            check($sformatf("v%0d_fail_valid", i), int'(fail_valid), vecs[i].exp_fv);
            check($sformatf("v%0d_pass", i), int'(pass), int'(vecs[i].exp_err == 0));
            check($sformatf("v%0d_finish_idle", i), int'({busy, A, B, C, D}), 0);
        end

        // FINISH holds its results while start stays low.
        repeat (10) @(posedge clk);
        #1;
        check("finish_hold_done", int'(done), 1);
        check("finish_hold_err", int'(err_count), 1);

        // Abort a run 30 cycles in, after errors have accumulated.
        mode = M_ZERO;
        @(negedge clk);
        expected = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("pre_abort_err", int'(err_count), 7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("abort_outputs", all_outs(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) bad++;
        end
        check("abort_no_done", bad, 0);

        mode = M_AND;
        run_one(16'hF000, -1, dc, se, ae);
        check("post_abort_done_cycle", dc, RUN_CYCLES);
        check("post_abort_steps", se, 0);
        check("post_abort_err", int'(err_count), 0);
        check("post_abort_pass", int'(pass), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD, default 4, giving the clock cycles each input pattern is held; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  run request, sampled on the rising edge of clk.
REQ-005 expected  input  16  golden truth table; bit i is the expected DUT output for pattern i.
REQ-006 dut_out  input  1  output of the combinational function under test.
REQ-007 A, B, C, D  output  1 each  stimulus bits; {A,B,C,D} SHALL equal the current pattern index, with A as MSB.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high from run completion until the next accepted start.
REQ-010 pass  output  1  high when done=1 and err_count=0.
REQ-011 err_count  output  5  number of mismatching patterns in the current or last run, range 0..16.
REQ-012 first_fail  output  4  index of the lowest failing pattern; valid only when fail_valid=1.
REQ-013 fail_valid  output  1  set when the first mismatch of a run is recorded.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-015 The FSM SHALL move IDLE->RUN or FINISH->RUN on a clock edge with start=1; on that edge it SHALL set pattern index 0 and hold counter 0, clear err_count, first_fail and fail_valid, clear done, and latch expected into an internal register.
REQ-016 The FSM SHALL ignore start while in RUN, with no effect on any state.
REQ-017 In RUN, busy SHALL be 1 and {A,B,C,D} SHALL equal the index; the first pattern (0000) SHALL appear on the edge that accepts start.
REQ-018 Each pattern SHALL be driven for exactly HOLD cycles; the hold counter SHALL count 0..HOLD-1 and then wrap to 0 as the index increments.
REQ-019 On the edge ending the last hold cycle (hold counter = HOLD-1), dut_out SHALL be compared with latched_expected[index].
REQ-020 On a mismatch, err_count SHALL increment; if fail_valid=0, first_fail SHALL take the index and fail_valid SHALL be set.
REQ-021 Later mismatches in the same run SHALL leave first_fail unchanged.
REQ-022 After the compare at index 15, the FSM SHALL go to FINISH on the same edge.
REQ-023 That edge SHALL make busy=0, done=1 and {A,B,C,D}=0000, and SHALL include the index-15 result in err_count.
REQ-024 A run SHALL last 16*HOLD cycles from the start-accepting edge to the done-rising edge.
REQ-025 Changes on expected during RUN SHALL have no effect; only the value latched at start is used.
REQ-026 FINISH SHALL hold done, pass, err_count, first_fail and fail_valid until the next accepted start.
REQ-027 err_count SHALL NOT wrap, since its maximum value of 16 fits in 5 bits.
REQ-028 pass SHALL be combinational from done and err_count and SHALL be 0 whenever done=0.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for clk, force the state to IDLE.
REQ-030 rst SHALL also set A=B=C=D=0, busy=0, done=0, err_count=0, first_fail=0, fail_valid=0, the index and hold counter to 0, and latched_expected to 0.
REQ-031 A reset during RUN SHALL abort the run with no done pulse.
REQ-032 The first start after rst deasserts SHALL begin a clean run.

Verification (HOLD=4)
REQ-033 Reset, start held 0 for 100 cycles -> all outputs 0, busy never asserted.
REQ-034 expected=16'hF000, dut_out=A&B, one-cycle start -> ABCD steps 0000..1111 every 4 cycles; done rises 64 cycles after start; err_count=0; pass=1.
REQ-035 expected=16'hF000, dut_out=0 -> err_count=4, first_fail=12, fail_valid=1, pass=0.
REQ-036 start re-pulsed 20 cycles into a run, and expected changed to 16'h0000 mid-run -> no effect; done still at cycle 64; result identical to REQ-034.
REQ-037 rst pulsed 30 cycles into a run -> outputs 0 at once, done stays 0; a new start then completes the REQ-034 result in 64 cycles.
REQ-038 Two back-to-back runs, with start issued while in FINISH -> done drops on the accepting edge; counters clear; the second run is independent of the first.
